// File: rtl/complex_magnitude.sv
// Sequential |z| unit: power re^2+im^2 followed by a bit-serial integer square root.
// Optional build macro MAG_ROUND_EN selects round-to-nearest magnitude instead of floor.
//
// state  | meaning
// IDLE   | waiting for a sample, in_ready high
// SQUARE | forming the power and seeding the root iteration
// ROOT   | one root bit per cycle, MSB first
// DONE   | result held until out_ready
module complex_magnitude #(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2*DATA_W-1:0]   in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2*DATA_W-1:0]   out_power,
    output logic [DATA_W-1:0]     out_mag
);
    localparam int PW    = 2 * DATA_W;
    localparam int RW    = DATA_W + 2;
    localparam int CNT_W = $clog2(DATA_W) + 1;

    typedef enum logic [1:0] {IDLE, SQUARE, ROOT, DONE} state_t;

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  re_q, re_d, im_q, im_d;
    logic [PW-1:0]      power_q, power_d;
    logic [PW-1:0]      rad_q, rad_d;
    logic [DATA_W-1:0]  root_q, root_d;
    logic [RW-1:0]      rem_q, rem_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [PW-1:0]      out_power_q, out_power_d;
    logic [DATA_W-1:0]  out_mag_q, out_mag_d;

    logic [PW-1:0]      re_ext, im_ext, power_sum;
    logic [RW-1:0]      rem_shift, trial, diff, rem_next;
    logic               take;
    logic [DATA_W-1:0]  root_next, mag_final;

    always_comb begin
        re_ext    = {{DATA_W{re_q[DATA_W-1]}}, re_q};
        im_ext    = {{DATA_W{im_q[DATA_W-1]}}, im_q};
        // Both squares are non-negative, so the wrapped sum is the exact unsigned power.
        power_sum = re_ext * re_ext + im_ext * im_ext;

        // The remainder never reaches its top two bits before the last shift;
        // folding them into take keeps the datapath exact if that ever changed.
        rem_shift = {rem_q[DATA_W-1:0], rad_q[PW-1 -: 2]};
        trial     = {root_q, 2'b01};
        diff      = rem_shift - trial;
        take      = (rem_q[RW-1:RW-2] != 2'b00) || (rem_shift >= trial);
        rem_next  = take ? diff : rem_shift;
        root_next = {root_q[DATA_W-2:0], take};

        mag_final = root_next;
`ifdef MAG_ROUND_EN
        if (rem_next > {2'b00, root_next}) begin
            mag_final = root_next + DATA_W'(1);
        end
`else
`endif
    end

    always_comb begin
        state_d     = state_q;
        re_d        = re_q;
        im_d        = im_q;
        power_d     = power_q;
        rad_d       = rad_q;
        root_d      = root_q;
        rem_d       = rem_q;
        cnt_d       = cnt_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_power_d = out_power_q;
        out_mag_d   = out_mag_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    re_d       = in_data[PW-1:DATA_W];
                    im_d       = in_data[DATA_W-1:0];
                    in_ready_d = 1'b0;
                    state_d    = SQUARE;
                end
            end
            SQUARE: begin
                power_d = power_sum;
                rad_d   = power_sum;
                root_d  = '0;
                rem_d   = '0;
                cnt_d   = CNT_W'(DATA_W - 1);
                state_d = ROOT;
            end
            ROOT: begin
                rad_d  = {rad_q[PW-3:0], 2'b00};
                root_d = root_next;
                rem_d  = rem_next;
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    out_valid_d = 1'b1;
                    out_power_d = power_q;
                    out_mag_d   = mag_final;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            re_q        <= '0;
            im_q        <= '0;
            power_q     <= '0;
            rad_q       <= '0;
            root_q      <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_power_q <= '0;
            out_mag_q   <= '0;
        end else begin
            state_q     <= state_d;
            re_q        <= re_d;
            im_q        <= im_d;
            power_q     <= power_d;
            rad_q       <= rad_d;
            root_q      <= root_d;
            rem_q       <= rem_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_power_q <= out_power_d;
            out_mag_q   <= out_mag_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_power = out_power_q;
    assign out_mag   = out_mag_q;

endmodule

// File: tb/tb_complex_magnitude.sv
// Scoreboard bench for complex_magnitude: expected power/magnitude queued at accept, checked at output.
module tb_complex_magnitude;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [2*W-1:0] in_data = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [2*W-1:0] out_power;
    logic [W-1:0]   out_mag;

    int total = 0;
    int bad   = 0;
    logic [3*W-1:0] exp_q[$];

    always #5 clk = ~clk;

    complex_magnitude #(.DATA_W(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_power(out_power), .out_mag(out_mag)
    );

    function automatic logic [2*W-1:0] model_power(input logic [W-1:0] re, input logic [W-1:0] im);
        longint sre, sim;
        logic [2*W-1:0] p;
        sre = longint'($signed(re));
        sim = longint'($signed(im));
        p = 64'(sre * sre) + 64'(sim * sim);
        return p;
    endfunction

    function automatic logic [W-1:0] model_mag(input logic [2*W-1:0] p);
        logic [127:0] lo, hi, mid, sq;
        lo = 0;
        hi = 128'h0000_0000_FFFF_FFFF;
        while (lo < hi) begin
            mid = (lo + hi + 1) >> 1;
            sq  = mid * mid;
            if (sq <= {64'd0, p}) lo = mid;
            else hi = mid - 1;
        end
`ifdef MAG_ROUND_EN
        if (({64'd0, p} - lo * lo) > lo) lo = lo + 1;
`endif
        return lo[W-1:0];
    endfunction

    task automatic drive_sample(input logic [W-1:0] re, input logic [W-1:0] im);
        int n = 0;
        logic [2*W-1:0] p;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1; n++;
        end
        total++;
        if (!in_ready) begin
            bad++;
            $display("FAIL drive_ready_timeout: in_ready=%0b required 1", in_ready);
        end
        in_valid = 1'b1;
        in_data  = {re, im};
        @(posedge clk); #1;
        in_valid = 1'b0;
        p = model_power(re, im);
        exp_q.push_back({p, model_mag(p)});
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
        total++; if (out_power !== '0) begin bad++; $display("FAIL reset_out_power: got %0h want 0", out_power); end
        total++; if (out_mag !== '0) begin bad++; $display("FAIL reset_out_mag: got %0h want 0", out_mag); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int lat = 0;
        logic rdy_seen = 1'b0;
        logic [3*W-1:0] e;
        drive_sample(W'(3), W'(4));
        while (!out_valid && lat < 200) begin
            if (in_ready) rdy_seen = 1'b1;
            @(posedge clk); #1; lat++;
        end
        total++; if (rdy_seen !== 1'b0) begin bad++; $display("FAIL basic_in_ready_busy: got 1 want 0"); end
        total++; if (lat != 33) begin bad++; $display("FAIL basic_latency: got %0d want 33", lat); end
        e = exp_q.pop_front();
        total++; if (out_power !== e[3*W-1:W] || out_power !== 64'd25) begin bad++; $display("FAIL basic_power: got %0d want %0d", out_power, e[3*W-1:W]); end
        total++; if (out_mag !== e[W-1:0] || out_mag !== 32'd5) begin bad++; $display("FAIL basic_mag: got %0d want %0d", out_mag, e[W-1:0]); end
        handshake();
        total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL basic_after_hs: in_ready=%0b out_valid=%0b want 1/0", in_ready, out_valid); end
    endtask

    task automatic test_round();
        int lat;
        logic [3*W-1:0] e;
        logic [W-1:0] want;
`ifdef MAG_ROUND_EN
        want = 32'd3;
`else
        want = 32'd2;
`endif
        drive_sample(W'(2), -W'(2));
        wait_out(lat);
        e = exp_q.pop_front();
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL round_timeout: out_valid=%0b want 1", out_valid); end
        total++; if (out_power !== e[3*W-1:W] || out_power !== 64'd8) begin bad++; $display("FAIL round_power: got %0d want 8", out_power); end
        total++; if (out_mag !== e[W-1:0] || out_mag !== want) begin bad++; $display("FAIL round_mag: got %0d want %0d", out_mag, want); end
        handshake();
    endtask

    task automatic test_max();
        int lat;
        logic [3*W-1:0] e;
        logic [W-1:0] want;
`ifdef MAG_ROUND_EN
        want = 32'd3037000500;
`else
        want = 32'd3037000499;
`endif
        drive_sample(32'h8000_0000, 32'h8000_0000);
        wait_out(lat);
        e = exp_q.pop_front();
        total++; if (out_power !== e[3*W-1:W] || out_power !== 64'h8000_0000_0000_0000) begin bad++; $display("FAIL max_power: got %0h want 8000000000000000", out_power); end
        total++; if (out_mag !== e[W-1:0] || out_mag !== want) begin bad++; $display("FAIL max_mag: got %0d want %0d", out_mag, want); end
        handshake();
    endtask

    task automatic test_back_to_back();
        int lat;
        int errs = 0;
        logic [3*W-1:0] e;
        drive_sample(W'(7), -W'(9));
        wait_out(lat);
        e = exp_q.pop_front();
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = {$urandom(), $urandom()};
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
                out_power !== e[3*W-1:W] || out_mag !== e[W-1:0]) errs++;
        end
        in_valid = 1'b0;
        total++; if (errs != 0) begin bad++; $display("FAIL backpressure_hold: %0d bad cycles, want 0 (power=%0d mag=%0d)", errs, out_power, out_mag); end
        handshake();
        drive_sample(W'(0), W'(0));
        wait_out(lat);
        e = exp_q.pop_front();
        total++; if (lat != 33) begin bad++; $display("FAIL stream_latency: got %0d want 33", lat); end
        total++; if (out_power !== 64'd0 || out_mag !== 32'd0 || e[3*W-1:0] !== '0) begin bad++; $display("FAIL stream_zero: power=%0d mag=%0d want 0/0", out_power, out_mag); end
        handshake();
    endtask

    task automatic test_random();
        int lat;
        logic [3*W-1:0] e;
        for (int i = 0; i < 8; i++) begin
            drive_sample($urandom(), $urandom());
            wait_out(lat);
            e = exp_q.pop_front();
            total++; if (out_power !== e[3*W-1:W]) begin bad++; $display("FAIL rand_power[%0d]: got %0h want %0h", i, out_power, e[3*W-1:W]); end
            total++; if (out_mag !== e[W-1:0]) begin bad++; $display("FAIL rand_mag[%0d]: got %0d want %0d", i, out_mag, e[W-1:0]); end
            handshake();
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        int seen = 0;
        logic [3*W-1:0] e;
        drive_sample(W'(100), W'(100));
        repeat (5) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        exp_q.delete();
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        total++; if (seen != 0) begin bad++; $display("FAIL reset_mid_no_output: out_valid high %0d cycles want 0", seen); end
        drive_sample(W'(1), W'(1));
        wait_out(lat);
        e = exp_q.pop_front();
        total++; if (lat != 33) begin bad++; $display("FAIL reset_mid_latency: got %0d want 33", lat); end
        total++; if (out_power !== e[3*W-1:W] || out_mag !== e[W-1:0]) begin bad++; $display("FAIL reset_mid_result: power=%0d mag=%0d want %0d/%0d", out_power, out_mag, e[3*W-1:W], e[W-1:0]); end
        handshake();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_round();
        test_max();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
